// File: rtl/rfphoenix_pma_checker_if.sv
// Request, region-lookup and response signals of the PMA checker stage.
// The checker takes the slave view; the upstream/downstream/lookup side takes the master view.
interface rfphoenix_pma_checker_if #(
  parameter int AWID = 48,
  parameter int TIDW = 4
);
  logic            req_v;
  logic            req_rdy;
  logic [AWID-1:0] req_adr;
  logic [1:0]      req_cmd;
  logic [TIDW-1:0] req_tid;
  logic [AWID-1:0] rgn_adr;
  logic [3:0]      rgn_num;
  logic [19:0]     rgn_at;
  logic            rgn_err;
  logic            rsp_v;
  logic            rsp_rdy;
  logic [AWID-1:0] rsp_adr;
  logic [1:0]      rsp_cmd;
  logic [TIDW-1:0] rsp_tid;
  logic [3:0]      rsp_region;
  logic            rsp_cacheable;
  logic            rsp_fault;
  logic [2:0]      rsp_cause;

  modport slave (
    input  req_v, req_adr, req_cmd, req_tid,
    output req_rdy,
    output rgn_adr,
    input  rgn_num, rgn_at, rgn_err,
    output rsp_v, rsp_adr, rsp_cmd, rsp_tid, rsp_region, rsp_cacheable, rsp_fault, rsp_cause,
    input  rsp_rdy
  );

  modport master (
    output req_v, req_adr, req_cmd, req_tid,
    input  req_rdy,
    input  rgn_adr,
    output rgn_num, rgn_at, rgn_err,
    input  rsp_v, rsp_adr, rsp_cmd, rsp_tid, rsp_region, rsp_cacheable, rsp_fault, rsp_cause,
    output rsp_rdy
  );
endinterface

// File: rtl/rfphoenix_pma_checker.sv
// Physical-memory-attribute check stage: S1 holds the request while the region lookup runs,
// S2 holds the checked response. The first fault is captured in sticky registers and all faults are counted.
module rfphoenix_pma_checker #(
  parameter int AWID = 48,
  parameter int TIDW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rfphoenix_pma_checker_if.slave bus,
  input  logic                   flt_clr,
  output logic                   flt_v,
  output logic [AWID-1:0]        flt_adr,
  output logic [2:0]             flt_cause,
  output logic [TIDW-1:0]        flt_tid,
  output logic [7:0]             flt_cnt
);

  // perm = {R,W,X}; fld = attribute bits [15:8] (type in the low nibble, 8'hFF = vacant)
  function automatic logic [2:0] pma_cause(input logic [1:0] cmd, input logic [2:0] perm,
                                           input logic [7:0] fld, input logic err);
    logic [2:0] c;
    c = 3'd0;
    if (err) begin
      c = 3'd1;
    end else if (fld == 8'hFF) begin
      c = 3'd2;
    end else begin
      case (cmd)
        2'd1:    c = perm[1] ? 3'd0 : 3'd4;
        2'd2:    c = !perm[0] ? 3'd5 : ((fld[3:0] == 4'd2) ? 3'd6 : 3'd0);
        default: c = perm[2] ? 3'd0 : 3'd3;
      endcase
    end
    return c;
  endfunction

  logic            s1_v_r;
  logic [AWID-1:0] s1_adr_r;
  logic [1:0]      s1_cmd_r;
  logic [TIDW-1:0] s1_tid_r;
  logic            s2_v_r;
  logic [AWID-1:0] s2_adr_r;
  logic [1:0]      s2_cmd_r;
  logic [TIDW-1:0] s2_tid_r;
  logic [3:0]      s2_region_r;
  logic            s2_cacheable_r;
  logic            s2_fault_r;
  logic [2:0]      s2_cause_r;
  logic            flt_v_r;
  logic [AWID-1:0] flt_adr_r;
  logic [2:0]      flt_cause_r;
  logic [TIDW-1:0] flt_tid_r;
  logic [7:0]      flt_cnt_r;

  logic            s2_adv_s;
  logic            s1_adv_s;
  logic            req_rdy_s;
  logic            accept_s;
  logic [2:0]      cause_s;
  logic            fault_s;
  logic            cacheable_s;
  logic            unused_at_s;

  assign unused_at_s = ^{bus.rgn_at[19:16], bus.rgn_at[7:4]};

  // Handshake qualifiers and the attribute check on the S1 lookup result
  always_comb begin
    s2_adv_s    = 1'b0;
    s1_adv_s    = 1'b0;
    req_rdy_s   = 1'b0;
    accept_s    = 1'b0;
    cause_s     = 3'd0;
    fault_s     = 1'b0;
    cacheable_s = 1'b0;
    s2_adv_s    = !s2_v_r || bus.rsp_rdy;
    s1_adv_s    = s1_v_r && s2_adv_s;
    req_rdy_s   = !s1_v_r || s2_adv_s;
    accept_s    = bus.req_v && req_rdy_s;
    cause_s     = pma_cause(s1_cmd_r, bus.rgn_at[2:0], bus.rgn_at[15:8], bus.rgn_err);
    fault_s     = (cause_s != 3'd0);
    cacheable_s = bus.rgn_at[3] && !fault_s;
  end

  // S1/S2 pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r         <= 1'b0;
      s1_adr_r       <= {AWID{1'b0}};
      s1_cmd_r       <= 2'd0;
      s1_tid_r       <= {TIDW{1'b0}};
      s2_v_r         <= 1'b0;
      s2_adr_r       <= {AWID{1'b0}};
      s2_cmd_r       <= 2'd0;
      s2_tid_r       <= {TIDW{1'b0}};
      s2_region_r    <= 4'd0;
      s2_cacheable_r <= 1'b0;
      s2_fault_r     <= 1'b0;
      s2_cause_r     <= 3'd0;
    end else begin
      if (accept_s) begin
        s1_v_r   <= 1'b1;
        s1_adr_r <= bus.req_adr;
        s1_cmd_r <= bus.req_cmd;
        s1_tid_r <= bus.req_tid;
      end else if (s1_adv_s) begin
        s1_v_r <= 1'b0;
      end else begin
        s1_v_r <= s1_v_r;
      end
      if (s1_adv_s) begin
        s2_v_r         <= 1'b1;
        s2_adr_r       <= s1_adr_r;
        s2_cmd_r       <= s1_cmd_r;
        s2_tid_r       <= s1_tid_r;
        s2_region_r    <= bus.rgn_num;
        s2_cacheable_r <= cacheable_s;
        s2_fault_r     <= fault_s;
        s2_cause_r     <= cause_s;
      end else if (s2_adv_s) begin
        s2_v_r <= 1'b0;
      end else begin
        s2_v_r <= s2_v_r;
      end
    end
  end

  // Sticky first-fault capture and saturating fault counter; a clear coinciding with a fault restarts at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_v_r     <= 1'b0;
      flt_adr_r   <= {AWID{1'b0}};
      flt_cause_r <= 3'd0;
      flt_tid_r   <= {TIDW{1'b0}};
      flt_cnt_r   <= 8'd0;
    end else if (s1_adv_s && fault_s) begin
      if (!flt_v_r || flt_clr) begin
        flt_v_r     <= 1'b1;
        flt_adr_r   <= s1_adr_r;
        flt_cause_r <= cause_s;
        flt_tid_r   <= s1_tid_r;
      end else begin
        flt_v_r <= flt_v_r;
      end
      if (flt_clr) begin
        flt_cnt_r <= 8'd1;
      end else if (flt_cnt_r != 8'hFF) begin
        flt_cnt_r <= flt_cnt_r + 8'd1;
      end else begin
        flt_cnt_r <= flt_cnt_r;
      end
    end else if (flt_clr) begin
      flt_v_r   <= 1'b0;
      flt_cnt_r <= 8'd0;
    end else begin
      flt_v_r <= flt_v_r;
    end
  end

  assign bus.req_rdy       = req_rdy_s;
  assign bus.rgn_adr       = s1_adr_r;
  assign bus.rsp_v         = s2_v_r;
  assign bus.rsp_adr       = s2_adr_r;
  assign bus.rsp_cmd       = s2_cmd_r;
  assign bus.rsp_tid       = s2_tid_r;
  assign bus.rsp_region    = s2_region_r;
  assign bus.rsp_cacheable = s2_cacheable_r;
  assign bus.rsp_fault     = s2_fault_r;
  assign bus.rsp_cause     = s2_cause_r;
  assign flt_v             = flt_v_r;
  assign flt_adr           = flt_adr_r;
  assign flt_cause         = flt_cause_r;
  assign flt_tid           = flt_tid_r;
  assign flt_cnt           = flt_cnt_r;

endmodule

// File: tb/tb_rfphoenix_pma_checker.sv
// Bench for rfphoenix_pma_checker: a 16-entry region table indexed by address bits [31:28]
// answers the lookup; a queue-based reference model predicts every response and the fault registers.
module tb_rfphoenix_pma_checker;
  localparam int AWID = 48;
  localparam int TIDW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flt_clr = 1'b0;
  logic            flt_v;
  logic [AWID-1:0] flt_adr;
  logic [2:0]      flt_cause;
  logic [TIDW-1:0] flt_tid;
  logic [7:0]      flt_cnt;

  rfphoenix_pma_checker_if #(.AWID(AWID), .TIDW(TIDW)) bus ();

  rfphoenix_pma_checker #(.AWID(AWID), .TIDW(TIDW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flt_clr(flt_clr), .flt_v(flt_v),
    .flt_adr(flt_adr), .flt_cause(flt_cause), .flt_tid(flt_tid), .flt_cnt(flt_cnt)
  );

  always #5 clk = ~clk;

  logic [19:0] tab_at [16];
  logic [3:0]  tab_num [16];
  logic        tab_err [16];
  logic        rdy_rand = 1'b0;
  logic        rdy_rnd = 1'b1;
  logic        rdy_fixed = 1'b1;

  assign bus.rgn_at  = tab_at[bus.rgn_adr[31:28]];
  assign bus.rgn_num = tab_num[bus.rgn_adr[31:28]];
  assign bus.rgn_err = tab_err[bus.rgn_adr[31:28]];
  assign bus.rsp_rdy = rdy_rand ? rdy_rnd : rdy_fixed;

  typedef struct {
    logic [47:0] adr;
    logic [1:0]  cmd;
    logic [3:0]  tid;
    logic [3:0]  region;
    logic        cacheable;
    logic        fault;
    logic [2:0]  cause;
  } exp_t;

  exp_t        expq[$];
  exp_t        m_e;
  logic [3:0]  tid_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_flt_v = 1'b0;
  logic [47:0] m_flt_adr = '0;
  logic [2:0]  m_flt_cause = '0;
  logic [3:0]  m_flt_tid = '0;
  int          m_flt_cnt = 0;
  logic [2:0]  last_cause = '0;
  logic        last_fault = 1'b0;
  logic        last_cach = 1'b0;
  logic [3:0]  last_region = '0;
  logic [3:0]  last_tid = '0;
  logic        saw_low = 1'b0;
  logic [47:0] first_adr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Spec rules: permission bit selected by access type, causes checked in priority order
  function automatic exp_t predict(input logic [47:0] a, input logic [1:0] c, input logic [3:0] t);
    exp_t        e;
    int          idx = int'(a[31:28]);
    logic [19:0] at = tab_at[idx];
    int          pb = (c == 2'd1) ? 1 : ((c == 2'd2) ? 0 : 2);
    int          cause = 0;
    if (tab_err[idx]) cause = 1;
    else if (at[15:8] == 8'hFF) cause = 2;
    else if (at[pb] == 1'b0) cause = 3 + ((c == 2'd3) ? 0 : int'(c));
    else if (c == 2'd2 && at[11:8] == 4'd2) cause = 6;
    e.adr = a; e.cmd = c; e.tid = t; e.region = tab_num[idx];
    e.cause = 3'(cause); e.fault = (cause != 0); e.cacheable = at[3] && (cause == 0);
    return e;
  endfunction

  // Response scoreboard and fault model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_v && bus.rsp_rdy) begin
        if (expq.size() == 0) begin
          check("stale_rsp", 64'(bus.rsp_v), 64'd0);
        end else begin
          m_e = expq.pop_front();
          check("rsp_adr", 64'(bus.rsp_adr), 64'(m_e.adr));
          check("rsp_cmd", 64'(bus.rsp_cmd), 64'(m_e.cmd));
          check("rsp_tid", 64'(bus.rsp_tid), 64'(m_e.tid));
          check("rsp_region", 64'(bus.rsp_region), 64'(m_e.region));
          check("rsp_fault", 64'(bus.rsp_fault), 64'(m_e.fault));
          check("rsp_cause", 64'(bus.rsp_cause), 64'(m_e.cause));
          check("rsp_cacheable", 64'(bus.rsp_cacheable), 64'(m_e.cacheable));
          last_cause = bus.rsp_cause; last_fault = bus.rsp_fault; last_cach = bus.rsp_cacheable;
          last_region = bus.rsp_region; last_tid = bus.rsp_tid;
          tid_log.push_back(bus.rsp_tid);
        end
      end
      if (bus.req_v && bus.req_rdy) begin
        m_e = predict(bus.req_adr, bus.req_cmd, bus.req_tid);
        expq.push_back(m_e);
        if (m_e.fault) begin
          if (!m_flt_v) begin
            m_flt_adr = m_e.adr; m_flt_cause = m_e.cause; m_flt_tid = m_e.tid;
          end
          m_flt_v = 1'b1;
          if (m_flt_cnt < 255) m_flt_cnt++;
        end
      end
    end
  end

  // Random ready pattern, used when rdy_rand is set
  always begin
    @(posedge clk); #1;
    rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [47:0] a, input logic [1:0] c, input logic [3:0] t);
    int k = 0;
    bus.req_adr = a; bus.req_cmd = c; bus.req_tid = t; bus.req_v = 1'b1;
    do begin @(negedge clk); k++; end while (!bus.req_rdy && k < 300);
    if (!bus.req_rdy) check("req_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_v = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (expq.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    check("drain", 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_flt();
    check("flt_v", 64'(flt_v), 64'(m_flt_v));
    check("flt_adr", 64'(flt_adr), 64'(m_flt_adr));
    check("flt_cause", 64'(flt_cause), 64'(m_flt_cause));
    check("flt_tid", 64'(flt_tid), 64'(m_flt_tid));
    check("flt_cnt", 64'(flt_cnt), 64'(m_flt_cnt));
  endtask

  task automatic clear_pulse();
    flt_clr = 1'b1;
    @(posedge clk); #1;
    flt_clr = 1'b0;
    m_flt_v = 1'b0; m_flt_cnt = 0;
    check("clr_v", 64'(flt_v), 64'd0);
    check("clr_cnt", 64'(flt_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_v = 1'b0; bus.req_adr = '0; bus.req_cmd = '0; bus.req_tid = '0;
    for (int i = 0; i < 16; i++) begin tab_at[i] = 20'h0010F; tab_num[i] = 4'(i); tab_err[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_v", 64'(bus.rsp_v), 64'd0);
    check("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
    check("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
    check("rst_rsp_cause", 64'(bus.rsp_cause), 64'd0);
    check("rst_rsp_cach", 64'(bus.rsp_cacheable), 64'd0);
    check("rst_rgn_adr", 64'(bus.rgn_adr), 64'd0);
    check_flt();
    @(posedge clk); #1;

    // Read hit with latency of two cycles from accept
    tab_at[0] = 20'h0010F; tab_num[0] = 4'd1;
    bus.req_adr = 48'h0000_0000_1000; bus.req_cmd = 2'd0; bus.req_tid = 4'd3; bus.req_v = 1'b1;
    @(negedge clk);
    check("t1_rdy", 64'(bus.req_rdy), 64'd1);
    @(posedge clk); #1 bus.req_v = 1'b0;
    @(negedge clk);
    check("t1_rgn_adr", 64'(bus.rgn_adr), 64'h1000);
    check("t1_lat_n1", 64'(bus.rsp_v), 64'd0);
    @(negedge clk);
    check("t1_lat_n2", 64'(bus.rsp_v), 64'd1);
    @(posedge clk); #1;
    drain();
    check("t1_fault", 64'(last_fault), 64'd0);
    check("t1_cach", 64'(last_cach), 64'd1);
    check("t1_region", 64'(last_region), 64'd1);
    check("t1_tid", 64'(last_tid), 64'd3);

    // Write to a non-writable region: first fault captured
    tab_at[15] = 20'h0000D;
    send(48'h0000_FFFD_0010, 2'd1, 4'd2);
    drain();
    check("t2_fault", 64'(last_fault), 64'd1);
    check("t2_cause", 64'(last_cause), 64'd4);
    check("t2_flt_v", 64'(flt_v), 64'd1);
    check("t2_flt_adr", 64'(flt_adr), 64'h0000_FFFD_0010);
    check("t2_flt_cause", 64'(flt_cause), 64'd4);
    check("t2_flt_cnt", 64'(flt_cnt), 64'd1);

    // Execute checks: X=0 outranks io, then io, lookup miss, vacant
    tab_at[15] = 20'h00206; send(48'h0000_FF80_0000, 2'd2, 4'd4); drain();
    check("t3_noexec", 64'(last_cause), 64'd5);
    tab_at[15] = 20'h00207; send(48'h0000_FF80_0000, 2'd2, 4'd4); drain();
    check("t3_io", 64'(last_cause), 64'd6);
    tab_err[15] = 1'b1; send(48'h0000_FF80_0000, 2'd2, 4'd4); drain();
    check("t3_miss", 64'(last_cause), 64'd1);
    tab_err[15] = 1'b0; tab_at[15] = 20'h0FF00; send(48'h0000_FF80_0000, 2'd2, 4'd4); drain();
    check("t3_vacant", 64'(last_cause), 64'd2);
    check_flt();

    // Four back-to-back reads with a three-cycle response stall
    tid_log.delete();
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(48'h0000_0000_0100 + 48'(i * 16), 2'd0, 4'(8 + i));
      end
      begin
        repeat (2) @(posedge clk);
        #1 rdy_fixed = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          if (!bus.req_rdy) saw_low = 1'b1;
          @(posedge clk); #1;
        end
        rdy_fixed = 1'b1;
      end
    join
    drain();
    check("t4_rdy_dropped", 64'(saw_low), 64'd1);
    check("t4_count", 64'(tid_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < tid_log.size(); i++) check("t4_order", 64'(tid_log[i]), 64'(8 + i));

    // Randomized epochs against the model
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 16; i++) begin
        tab_at[i] = 20'($urandom);
        tab_at[i][11:8] = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) tab_at[i][15:8] = 8'hFF;
        tab_err[i] = ($urandom_range(0, 7) == 0);
        tab_num[i] = 4'($urandom);
      end
      rdy_rand = 1'b1;
      for (int k = 0; k < 60; k++) begin
        send({16'($urandom), 32'($urandom)}, 2'($urandom), 4'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      drain();
      rdy_rand = 1'b0;
      check_flt();
      if (ep % 2 == 1) clear_pulse();
    end

    // 300 faults: counter saturates, first fault stays captured
    for (int i = 0; i < 16; i++) begin tab_at[i] = 20'h0010F; tab_err[i] = 1'b0; end
    tab_err[3] = 1'b1;
    clear_pulse();
    first_adr = 48'h0000_3000_0000;
    for (int k = 0; k < 300; k++) send(first_adr + 48'(k * 4), 2'($urandom), 4'(k));
    drain();
    check("t5_cnt", 64'(flt_cnt), 64'd255);
    check("t5_adr", 64'(flt_adr), 64'(first_adr));
    check_flt();

    // Clear coinciding with a new fault
    tab_err[2] = 1'b1;
    send(48'h0000_2000_0000, 2'd0, 4'd5);
    flt_clr = 1'b1;
    @(posedge clk); #1 flt_clr = 1'b0;
    drain();
    check("t6_cnt", 64'(flt_cnt), 64'd1);
    check("t6_adr", 64'(flt_adr), 64'h0000_2000_0000);
    check("t6_v", 64'(flt_v), 64'd1);
    m_flt_v = 1'b1; m_flt_adr = 48'h0000_2000_0000; m_flt_cause = 3'd1; m_flt_tid = 4'd5; m_flt_cnt = 1;

    // Reset with both stages full drops everything
    rdy_fixed = 1'b0;
    send(48'h0000_0000_0040, 2'd0, 4'd1);
    send(48'h0000_0000_0080, 2'd0, 4'd2);
    @(negedge clk);
    check("t7_full_rdy", 64'(bus.req_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; bus.req_v = 1'b1; flt_clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.req_v = 1'b0; flt_clr = 1'b0;
    expq.delete();
    m_flt_v = 1'b0; m_flt_adr = '0; m_flt_cause = '0; m_flt_tid = '0; m_flt_cnt = 0;
    @(negedge clk);
    check("t7_rsp_v", 64'(bus.rsp_v), 64'd0);
    check("t7_req_rdy", 64'(bus.req_rdy), 64'd1);
    check_flt();
    rdy_fixed = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t7_no_stale", 64'(bus.rsp_v), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
